// File: rtl/fetch_pc_stage_pkg.sv
// Shared types and constants for the fetch PC stage.
//   fetch_state_t : FSM encoding (S_BOOT, S_RUN, S_HALT)
//   PC_LSB        : number of PC bits below the instruction granule for the
//                   default 4-byte instruction size
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  localparam int DEF_INSTR_BYTES = 4;
  localparam int PC_LSB          = $clog2(DEF_INSTR_BYTES);

endpackage

// File: rtl/fetch_pc_stage_if.sv
// Fetch-to-decode handshake bundle.
//   out_valid : PC on out_pc is valid (driven by fetch)
//   out_pc    : fetch address (driven by fetch)
//   out_ready : decode accepts out_pc (driven by decode)
// Handshake: a transfer happens on a rising clock edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// producer keeps out_pc stable, except that a redirect may replace it.
interface fetch_pc_stage_if #(
  parameter int ADDR_W = 32
);
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;

  modport master (output out_valid, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_pc_stage_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears count
//   en    : increment by one this cycle (ignored once count is all-ones)
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch-side program-counter stage. Issues sequential instruction addresses
// to decode over a valid/ready handshake, accepts redirects and halt
// requests, and counts accepted fetches (saturating).
// Ports:
//   clk, reset      : clock (rising edge), asynchronous active-high reset
//   redirect_valid  : load redirect_pc this cycle
//   redirect_pc     : redirect target
//   halt_req        : level request to stop issuing PCs
//   dec             : fetch_pc_stage_if master (out_valid/out_pc/out_ready)
//   halted          : stage is in S_HALT
//   fetch_count     : accepted handshakes, saturating at all-ones
//   dbg_state       : current FSM state
//   misalign_err    : one-cycle pulse on a misaligned redirect
//                     (only when FETCH_MISALIGN_TRAP_EN is defined)
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirects are refused and
// trap into S_HALT. Without it, redirect targets have their low bits cleared.
module fetch_pc_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                INSTR_BYTES  = 4,
  parameter int                CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  input  logic                 halt_req,
  fetch_pc_stage_if.master     dec,
  output logic                 halted,
  output logic [CNT_W-1:0]     fetch_count,
  output fetch_state_t         dbg_state
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                 misalign_err
`endif
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INSTR_BYTES);

  fetch_state_t      state, state_d;
  logic              valid_d;
  logic [ADDR_W-1:0] pc_d;
  logic              xfer;
  logic              redirect_misaligned;
  logic [ADDR_W-1:0] aligned_target;
  logic [ADDR_W-1:0] pc_after_xfer;

  assign xfer           = dec.out_valid & dec.out_ready;
  assign aligned_target = redirect_pc & ~LOW_MASK;
  // Wraps modulo 2^ADDR_W by truncation; no overflow flag.
  assign pc_after_xfer  = xfer ? (dec.out_pc + PC_STEP) : dec.out_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_misaligned = |(redirect_pc & LOW_MASK);
`else
  assign redirect_misaligned = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_BOOT;
      dec.out_valid <= 1'b0;
      dec.out_pc    <= RESET_VECTOR;
    end else begin
      state         <= state_d;
      dec.out_valid <= valid_d;
      dec.out_pc    <= pc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (state)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (redirect_valid) begin
          state_d = redirect_misaligned ? S_HALT : S_RUN;
        end else if (halt_req && (!dec.out_valid || dec.out_ready)) begin
          // A stalled PC is never dropped by halt: wait for its transfer.
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          state_d = redirect_misaligned ? S_HALT : S_RUN;
        end else if (!halt_req) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Output / datapath next-value logic.
  always_comb begin
    valid_d = dec.out_valid;
    pc_d    = dec.out_pc;
    unique case (state)
      S_BOOT: begin
        valid_d = 1'b1;
        pc_d    = RESET_VECTOR;
      end
      S_RUN: begin
        if (redirect_valid) begin
          if (redirect_misaligned) begin
            valid_d = 1'b0;
            pc_d    = pc_after_xfer;
          end else begin
            // Any unaccepted PC is replaced by the target.
            valid_d = 1'b1;
            pc_d    = aligned_target;
          end
        end else if (halt_req && (!dec.out_valid || dec.out_ready)) begin
          valid_d = 1'b0;
          pc_d    = pc_after_xfer;
        end else begin
          pc_d    = pc_after_xfer;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          if (!redirect_misaligned) begin
            valid_d = 1'b1;
            pc_d    = aligned_target;
          end
        end else if (!halt_req) begin
          // Reissue the held PC.
          valid_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  assign halted    = (state == S_HALT);
  assign dbg_state = state;

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= (state != S_BOOT) && redirect_valid && redirect_misaligned;
    end
  end
`endif

  sat_counter #(.W(CNT_W)) u_fetch_count (
    .clk   (clk),
    .reset (reset),
    .en    (xfer),
    .count (fetch_count)
  );

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage: directed scenarios followed by
// randomized traffic, checked against a behavioural model with a scoreboard
// queue of expected accepted PCs.
module tb_fetch_pc_stage;
  import fetch_pkg::*;

  localparam int          ADDR_W = 32;
  localparam int          IB     = 4;
  localparam int          CNT_W  = 3;
  localparam logic [31:0] RV     = 32'h0000_0000;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt_req;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;
  fetch_state_t      dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic              misalign_err;
`endif

  fetch_pc_stage_if #(.ADDR_W(ADDR_W)) dec ();

  fetch_pc_stage #(
    .ADDR_W(ADDR_W), .RESET_VECTOR(RV), .INSTR_BYTES(IB), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .dec            (dec),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .dbg_state      (dbg_state)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [ADDR_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Mode names describe behaviour: booting, issuing, or parked.
  localparam int M_BOOT = 0, M_ISSUE = 1, M_PARK = 2;
  int          m_mode;
  bit          m_valid;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_merr;

  function automatic logic [31:0] next_pc(input logic [31:0] p);
    longint unsigned s;
    s = (longint'(p) + IB) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  function automatic void model_reset();
    m_mode = M_BOOT; m_valid = 0; m_pc = RV; m_cnt = 0; m_merr = 0;
  endfunction

  function automatic void model_step(input bit rv, input logic [31:0] rpc, input bit hr, input bit rdy);
    bit          took;
    bit          bad_align;
    logic [31:0] target;
    took      = m_valid && rdy;
    target    = rpc - (rpc % IB);
    bad_align = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    bad_align = (rpc % IB) != 0;
`endif
    m_merr = 0;
    if (took && m_cnt < CNT_MAX) m_cnt++;
    case (m_mode)
      M_BOOT: begin m_mode = M_ISSUE; m_valid = 1; m_pc = RV; end
      M_ISSUE: begin
        if (rv && bad_align) begin
          m_mode = M_PARK; m_valid = 0; m_merr = 1;
          if (took) m_pc = next_pc(m_pc);
        end else if (rv) begin
          m_pc = target; m_valid = 1;
        end else if (hr && (!m_valid || rdy)) begin
          m_mode = M_PARK; m_valid = 0;
          if (took) m_pc = next_pc(m_pc);
        end else if (took) begin
          m_pc = next_pc(m_pc);
        end
      end
      default: begin
        if (rv && bad_align) m_merr = 1;
        else if (rv) begin m_mode = M_ISSUE; m_pc = target; m_valid = 1; end
        else if (!hr) begin m_mode = M_ISSUE; m_valid = 1; end
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; drives one cycle of inputs.
  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit hr, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    dec.out_ready  = rdy;
    if (m_valid && rdy) exp_q.push_back(m_pc);
    @(posedge clk); #1;
    model_step(rv, rpc, hr, rdy);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 32'(dec.out_valid), 32'd0);
    chk({tag, "_pc"}, dec.out_pc, RV);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_count"}, 32'(fetch_count), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk({tag, "_merr"}, 32'(misalign_err), 32'd0);
`endif
  endtask

  // Asynchronous reset in the middle of a cycle; pending work is dropped.
  task automatic mid_reset();
    chk_en = 0;
    #1 reset = 1'b1;
    #1 check_reset_values("mid_reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk_en = 1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(dec.out_valid), 32'(m_valid));
      chk("out_pc", dec.out_pc, m_pc);
      chk("halted", 32'(halted), 32'(m_mode == M_PARK));
      chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("misalign_err", 32'(misalign_err), 32'(m_merr));
`endif
      if (dec.out_valid && dec.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("xfer_unexpected", dec.out_pc, 32'hDEAD_BEEF);
        end else begin
          chk("xfer_pc", dec.out_pc, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          hr_lvl;
    logic [31:0] rpc;
    reset = 1'b1; redirect_valid = 0; redirect_pc = '0; halt_req = 0; dec.out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    reset = 1'b0;
    chk_en = 1;

    // Boot then stream: 0x0, 0x4, 0x8, 0xC.
    cycle(0, '0, 0, 1);
    chk("first_pc_valid", 32'(dec.out_valid), 32'd1);
    chk("first_pc", dec.out_pc, 32'h0);
    repeat (4) cycle(0, '0, 0, 1);
    chk("count_after_4", 32'(fetch_count), 32'd4);
    chk("pc_after_4", dec.out_pc, 32'h10);
    // Stall at 0x10.
    repeat (5) cycle(0, '0, 0, 0);
    chk("stall_pc", dec.out_pc, 32'h10);
    repeat (4) cycle(0, '0, 0, 1);
    // Redirect while 0x20 stalls.
    cycle(0, '0, 0, 0);
    chk("stall_pc_20", dec.out_pc, 32'h20);
    cycle(1, 32'h100, 0, 0);
    chk("redirect_pc", dec.out_pc, 32'h100);
    // Move to 0x40 and halt during a stall there.
    cycle(1, 32'h40, 0, 1);
    repeat (3) cycle(0, '0, 1, 0);
    chk("halt_waits", 32'(dec.out_valid), 32'd1);
    cycle(0, '0, 1, 1);
    chk("halted_after_xfer", 32'(halted), 32'd1);
    repeat (2) cycle(0, '0, 1, 1);
    cycle(0, '0, 0, 1);
    chk("reissue_pc", dec.out_pc, 32'h44);
    // Wrap at the top of the address space.
    cycle(1, 32'hFFFF_FFFC, 0, 1);
    repeat (3) cycle(0, '0, 0, 1);
    chk("count_sat", 32'(fetch_count), 32'(CNT_MAX));
    // Misaligned redirect.
    cycle(1, 32'h102, 0, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_merr", 32'(misalign_err), 32'd1);
    chk("trap_halted", 32'(halted), 32'd1);
`else
    chk("align_pc", dec.out_pc, 32'h100);
`endif
    repeat (2) cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);
    mid_reset();

    // Randomized traffic.
    hr_lvl = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) hr_lvl = ~hr_lvl;
      case ($urandom_range(0, 2))
        0:       rpc = $urandom & 32'h0000_0FFF;
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = $urandom;
      endcase
      cycle($urandom_range(0, 9) == 0, rpc, hr_lvl, $urandom_range(0, 3) != 0);
      if (i == 400) mid_reset();
    end
    cycle(0, '0, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
